// File: rtl/lfo_sched.sv
// Time-multiplexed sine/cosine LFO: one shared MAC stepped over NCH channels.
// Optional LFO_RESYNC_EN adds per-channel phase reload (lfo_rst) at frame start.
module lfo_sched #(
   parameter int          NCH    = 4,
   parameter logic [31:0] INIT_S = 32'h3fffffff
) (
   input  logic               mclk_d16,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_ch,
   input  logic [8:0]         cfg_kfreq,
   input  logic [14:0]        cfg_amp,
`ifdef LFO_RESYNC_EN
   input  logic [NCH-1:0]     lfo_rst,
`endif
   output logic               busy,
   output logic               out_valid,
   output logic [2:0]         out_ch,
   output logic signed [31:0] sin_out,
   output logic signed [31:0] cos_out,
   output logic               frame_done,
   output logic               overrun
);

   typedef enum logic [2:0] {
      IDLE,
      S_UPD,
      C_UPD,
      A_SIN,
      A_COS,
      WB
   } state_t;

   state_t      state_q;
   logic [2:0]  ch_q;

   logic [31:0] s_q   [NCH];
   logic [31:0] c_q   [NCH];
   logic [8:0]  shk_q [NCH];
   logic [14:0] sha_q [NCH];
   logic [8:0]  ack_q [NCH];
   logic [14:0] aca_q [NCH];

   logic [31:0] sn_q;
   logic [31:0] cn_q;
   logic [31:0] sin_q;
   logic [31:0] cos_q;

   logic [31:0] s_cur;
   logic [31:0] c_cur;
   logic [8:0]  kf_cur;
   logic [14:0] amp_cur;

   logic signed [27:0] mul_a;
   logic signed [18:0] mul_b;
   logic signed [46:0] prod;
   logic [31:0]        mulf;
   logic [31:0]        mula;
   logic [31:0]        sn_d;
   logic [31:0]        cn_d;
   logic               unused_prod;

   always_comb begin
      s_cur   = '0;
      c_cur   = '0;
      kf_cur  = '0;
      amp_cur = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ch_q == 3'(i)) begin
            s_cur   = s_q[i];
            c_cur   = c_q[i];
            kf_cur  = ack_q[i];
            amp_cur = aca_q[i];
         end
      end
   end

   // Operand mux: kfreq steps use x[31:4], amplitude steps x[31:8] sign-extended
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         S_UPD: begin
            mul_a = c_cur[31:4];
            mul_b = {10'b0, kf_cur};
         end
         C_UPD: begin
            mul_a = sn_q[31:4];
            mul_b = {10'b0, kf_cur};
         end
         A_SIN: begin
            mul_a = {{4{sn_q[31]}}, sn_q[31:8]};
            mul_b = {4'b0, amp_cur};
         end
         A_COS: begin
            mul_a = {{4{cn_q[31]}}, cn_q[31:8]};
            mul_b = {4'b0, amp_cur};
         end
         default: begin
            mul_a = '0;
            mul_b = '0;
         end
      endcase
   end

   assign prod        = mul_a * mul_b;
   assign mulf        = prod[46:15];
   assign mula        = prod[38:7];
   assign sn_d        = s_cur + mulf;
   assign cn_d        = c_cur - mulf;
   assign unused_prod = ^prod[6:0];

   always_ff @(posedge mclk_d16) begin
      if (reset) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         sn_q       <= '0;
         cn_q       <= '0;
         sin_q      <= '0;
         cos_q      <= '0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         sin_out    <= '0;
         cos_out    <= '0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            s_q[i]   <= INIT_S;
            c_q[i]   <= '0;
            shk_q[i] <= '0;
            sha_q[i] <= '0;
            ack_q[i] <= '0;
            aca_q[i] <= '0;
         end
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;

         for (int i = 0; i < NCH; i++) begin
            if (cfg_we && cfg_ch == 3'(i)) begin
               shk_q[i] <= cfg_kfreq;
               sha_q[i] <= cfg_amp;
            end
         end

         if (frame_start && state_q != IDLE)
            overrun <= 1'b1;

         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  state_q <= S_UPD;
                  ch_q    <= '0;
                  busy    <= 1'b1;
                  for (int i = 0; i < NCH; i++) begin
                     // same-cycle config write is part of the snapshot
                     if (cfg_we && cfg_ch == 3'(i)) begin
                        ack_q[i] <= cfg_kfreq;
                        aca_q[i] <= cfg_amp;
                     end else begin
                        ack_q[i] <= shk_q[i];
                        aca_q[i] <= sha_q[i];
                     end
`ifdef LFO_RESYNC_EN
                     if (lfo_rst[i]) begin
                        s_q[i] <= INIT_S;
                        c_q[i] <= '0;
                     end
`endif
                  end
               end
            end
            S_UPD: begin
               sn_q    <= sn_d;
               state_q <= C_UPD;
            end
            C_UPD: begin
               cn_q    <= cn_d;
               state_q <= A_SIN;
            end
            A_SIN: begin
               sin_q   <= mula;
               state_q <= A_COS;
            end
            A_COS: begin
               cos_q   <= mula;
               state_q <= WB;
            end
            WB: begin
               for (int i = 0; i < NCH; i++) begin
                  if (ch_q == 3'(i)) begin
                     s_q[i] <= sn_q;
                     c_q[i] <= cn_q;
                  end
               end
               sin_out   <= sin_q;
               cos_out   <= cos_q;
               out_ch    <= ch_q;
               out_valid <= 1'b1;
               if (ch_q == 3'(NCH - 1)) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state_q    <= IDLE;
               end else begin
                  ch_q    <= ch_q + 3'd1;
                  state_q <= S_UPD;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
